// File: rtl/shift_sfr_seq.sv
// -----------------------------------------------------------------------------
// shift_sfr_seq
//
// Sequential special-function register. A single request (start) performs a
// load, increment, decrement, or a multi-cycle shift/rotate by 'amt' bits,
// one bit per clock. Every accepted operation ends with a one-cycle done pulse.
//
// Ports:
//   clk    in   1      clock, all state changes on the rising edge
//   clr    in   1      synchronous active-high reset
//   start  in   1      operation request, sampled only while busy=0
//   op     in   3      000 load, 001 incr, 010 decr, 011 shl, 100 shr,
//                      101 sar, 110 rol, 111 ror
//   amt    in   AMT_W  shift/rotate bit count (0 completes immediately)
//   din    in   SIZE   parallel load data
//   Q      out  SIZE   register contents
//   busy   out  1      high while a shift/rotate is in progress
//   done   out  1      one-cycle completion pulse
//   carry  out  1      status flag, present only with SHIFT_SFR_SEQ_CARRY_EN
//
// Build option: define SHIFT_SFR_SEQ_CARRY_EN to add the registered carry flag.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; load/incr/decr and amt=0 complete from here
// SHIFT | shifting Q one bit per clock until the counter reaches zero
// -----------------------------------------------------------------------------
module shift_sfr_seq #(
  parameter int SIZE  = 32,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic [SIZE-1:0]  din,
  output logic [SIZE-1:0]  Q,
  output logic             busy,
  output logic             done
`ifdef SHIFT_SFR_SEQ_CARRY_EN
  ,
  output logic             carry
`endif
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_INCR = 3'b001;
  localparam logic [2:0] OP_DECR = 3'b010;
  localparam logic [2:0] OP_SHL  = 3'b011;
  localparam logic [2:0] OP_SHR  = 3'b100;
  localparam logic [2:0] OP_SAR  = 3'b101;
  localparam logic [2:0] OP_ROL  = 3'b110;
  localparam logic [2:0] OP_ROR  = 3'b111;

  state_t           state;
  logic [2:0]       op_q;
  logic [AMT_W-1:0] cnt;
  logic [SIZE-1:0]  shifted;

  // busy is a pure decode of the state register, so it is glitch-free.
  assign busy = (state == SHIFT);

  // One-bit step of the latched shift/rotate.
  always_comb begin
    shifted = Q;
    case (op_q)
      OP_SHL:  shifted = {Q[SIZE-2:0], 1'b0};
      OP_SHR:  shifted = {1'b0, Q[SIZE-1:1]};
      OP_SAR:  shifted = {Q[SIZE-1], Q[SIZE-1:1]};
      OP_ROL:  shifted = {Q[SIZE-2:0], Q[SIZE-1]};
      OP_ROR:  shifted = {Q[0], Q[SIZE-1:1]};
      default: shifted = Q;
    endcase
  end

`ifdef SHIFT_SFR_SEQ_CARRY_EN
  logic shift_out;

  // Bit leaving the register on this step: MSB for left moves, LSB otherwise.
  always_comb begin
    shift_out = 1'b0;
    case (op_q)
      OP_SHL, OP_ROL:         shift_out = Q[SIZE-1];
      OP_SHR, OP_SAR, OP_ROR: shift_out = Q[0];
      default:                shift_out = 1'b0;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      op_q  <= OP_LOAD;
      cnt   <= '0;
      Q     <= '0;
      done  <= 1'b0;
`ifdef SHIFT_SFR_SEQ_CARRY_EN
      carry <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= op;
            cnt  <= amt;
            case (op)
              OP_LOAD: begin
                Q    <= din;
                done <= 1'b1;
`ifdef SHIFT_SFR_SEQ_CARRY_EN
                carry <= 1'b0;
`endif
              end
              OP_INCR: begin
                Q    <= Q + SIZE'(1);
                done <= 1'b1;
`ifdef SHIFT_SFR_SEQ_CARRY_EN
                carry <= (Q == '1);
`endif
              end
              OP_DECR: begin
                Q    <= Q - SIZE'(1);
                done <= 1'b1;
`ifdef SHIFT_SFR_SEQ_CARRY_EN
                carry <= (Q == '0);
`endif
              end
              default: begin
                // Zero-length shift completes at once; carry is held.
                if (amt == '0) done  <= 1'b1;
                else           state <= SHIFT;
              end
            endcase
          end
        end

        SHIFT: begin
          Q   <= shifted;
          cnt <= cnt - AMT_W'(1);
`ifdef SHIFT_SFR_SEQ_CARRY_EN
          carry <= shift_out;
`endif
          if (cnt == AMT_W'(1)) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sfr_seq.sv
module tb_shift_sfr_seq;

  localparam int SIZE  = 8;
  localparam int AMT_W = 3;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_INCR = 3'b001;
  localparam logic [2:0] OP_DECR = 3'b010;
  localparam logic [2:0] OP_SHL  = 3'b011;
  localparam logic [2:0] OP_SHR  = 3'b100;
  localparam logic [2:0] OP_SAR  = 3'b101;
  localparam logic [2:0] OP_ROL  = 3'b110;
  localparam logic [2:0] OP_ROR  = 3'b111;

  logic             clk = 1'b0;
  logic             clr;
  logic             start;
  logic [2:0]       op;
  logic [AMT_W-1:0] amt;
  logic [SIZE-1:0]  din;
  logic [SIZE-1:0]  Q;
  logic             busy;
  logic             done;
`ifdef SHIFT_SFR_SEQ_CARRY_EN
  logic             carry;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  shift_sfr_seq #(.SIZE(SIZE), .AMT_W(AMT_W)) dut (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .op    (op),
    .amt   (amt),
    .din   (din),
    .Q     (Q),
    .busy  (busy),
    .done  (done)
`ifdef SHIFT_SFR_SEQ_CARRY_EN
    ,
    .carry (carry)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one request from a negedge; returns at the negedge where the
  // operation has completed (busy low) and reports how many cycles busy
  // was observed high and whether done was high at completion.
  task automatic run_op(input logic [2:0] o, input logic [AMT_W-1:0] a,
                        input logic [SIZE-1:0] d,
                        output int busy_cycles, output logic done_seen);
    start = 1'b1; op = o; amt = a; din = d;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    busy_cycles = 0;
    while (busy && busy_cycles < 20) begin
      busy_cycles++;
      @(negedge clk);
    end
    done_seen = done;
  endtask

  task automatic test_reset();
    int bc;
    logic ds;
    clr = 1'b1; start = 1'b0; op = OP_LOAD; amt = '0; din = '0;
    @(posedge clk); @(negedge clk);
    clr = 1'b0;
    total_cnt++;
    if (Q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_init: Q=%h busy=%b done=%b, want 00 0 0", Q, busy, done);
    else pass_cnt++;
    // Activity, then clear mid-shift
    run_op(OP_LOAD, 3'd0, 8'hA5, bc, ds);
    start = 1'b1; op = OP_SHL; amt = 3'd5;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    clr = 1'b1;
    @(posedge clk); @(negedge clk);
    clr = 1'b0;
    total_cnt++;
    if (Q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_after_activity: Q=%h busy=%b done=%b, want 00 0 0", Q, busy, done);
    else pass_cnt++;
`ifdef SHIFT_SFR_SEQ_CARRY_EN
    total_cnt++;
    if (carry !== 1'b0) $display("FAIL reset_carry: carry=%b, want 0", carry);
    else pass_cnt++;
`endif
  endtask

  task automatic test_shift();
    int bc;
    logic ds;
    run_op(OP_LOAD, 3'd0, 8'h81, bc, ds);
    total_cnt++;
    if (Q !== 8'h81 || ds !== 1'b1 || bc != 0) $display("FAIL load_81: Q=%h done=%b busy_cycles=%0d, want 81 1 0", Q, ds, bc);
    else pass_cnt++;
    run_op(OP_SHL, 3'd3, 8'h00, bc, ds);
    total_cnt++;
    if (bc != 3) $display("FAIL shl3_busy: busy_cycles=%0d, want 3", bc);
    else pass_cnt++;
    total_cnt++;
    if (Q !== 8'h08 || ds !== 1'b1) $display("FAIL shl3_result: Q=%h done=%b, want 08 1", Q, ds);
    else pass_cnt++;
`ifdef SHIFT_SFR_SEQ_CARRY_EN
    total_cnt++;
    if (carry !== 1'b0) $display("FAIL shl3_carry: carry=%b, want 0", carry);
    else pass_cnt++;
`endif
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0 || Q !== 8'h08) $display("FAIL shl3_done_pulse: done=%b Q=%h, want 0 08", done, Q);
    else pass_cnt++;
  endtask

  task automatic test_arith_rotate();
    int bc;
    logic ds;
    run_op(OP_LOAD, 3'd0, 8'h80, bc, ds);
    run_op(OP_SAR, 3'd2, 8'h00, bc, ds);
    total_cnt++;
    if (Q !== 8'hE0 || bc != 2 || ds !== 1'b1) $display("FAIL sar2: Q=%h busy_cycles=%0d done=%b, want E0 2 1", Q, bc, ds);
    else pass_cnt++;
    run_op(OP_LOAD, 3'd0, 8'h01, bc, ds);
    run_op(OP_ROR, 3'd1, 8'h00, bc, ds);
    total_cnt++;
    if (Q !== 8'h80 || bc != 1) $display("FAIL ror1: Q=%h busy_cycles=%0d, want 80 1", Q, bc);
    else pass_cnt++;
`ifdef SHIFT_SFR_SEQ_CARRY_EN
    total_cnt++;
    if (carry !== 1'b1) $display("FAIL ror1_carry: carry=%b, want 1", carry);
    else pass_cnt++;
`endif
    run_op(OP_LOAD, 3'd0, 8'h81, bc, ds);
    run_op(OP_SHR, 3'd1, 8'h00, bc, ds);
    total_cnt++;
    if (Q !== 8'h40) $display("FAIL shr1: Q=%h, want 40", Q);
    else pass_cnt++;
`ifdef SHIFT_SFR_SEQ_CARRY_EN
    total_cnt++;
    if (carry !== 1'b1) $display("FAIL shr1_carry: carry=%b, want 1", carry);
    else pass_cnt++;
`endif
    run_op(OP_LOAD, 3'd0, 8'hC3, bc, ds);
    run_op(OP_ROL, 3'd3, 8'h00, bc, ds);
    total_cnt++;
    if (Q !== 8'h1E || bc != 3) $display("FAIL rol3: Q=%h busy_cycles=%0d, want 1E 3", Q, bc);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    int bc;
    logic ds;
    run_op(OP_LOAD, 3'd0, 8'hFF, bc, ds);
    run_op(OP_INCR, 3'd5, 8'h00, bc, ds);
    total_cnt++;
    if (Q !== 8'h00 || ds !== 1'b1 || bc != 0) $display("FAIL incr_wrap: Q=%h done=%b busy_cycles=%0d, want 00 1 0", Q, ds, bc);
    else pass_cnt++;
`ifdef SHIFT_SFR_SEQ_CARRY_EN
    total_cnt++;
    if (carry !== 1'b1) $display("FAIL incr_wrap_carry: carry=%b, want 1", carry);
    else pass_cnt++;
`endif
    run_op(OP_DECR, 3'd0, 8'h00, bc, ds);
    total_cnt++;
    if (Q !== 8'hFF || ds !== 1'b1) $display("FAIL decr_wrap: Q=%h done=%b, want FF 1", Q, ds);
    else pass_cnt++;
`ifdef SHIFT_SFR_SEQ_CARRY_EN
    total_cnt++;
    if (carry !== 1'b1) $display("FAIL decr_wrap_carry: carry=%b, want 1", carry);
    else pass_cnt++;
`endif
    run_op(OP_LOAD, 3'd0, 8'h10, bc, ds);
    run_op(OP_INCR, 3'd0, 8'h00, bc, ds);
    run_op(OP_INCR, 3'd0, 8'h00, bc, ds);
    run_op(OP_DECR, 3'd0, 8'h00, bc, ds);
    total_cnt++;
    if (Q !== 8'h11) $display("FAIL incr_decr_plain: Q=%h, want 11", Q);
    else pass_cnt++;
`ifdef SHIFT_SFR_SEQ_CARRY_EN
    total_cnt++;
    if (carry !== 1'b0) $display("FAIL incr_decr_plain_carry: carry=%b, want 0", carry);
    else pass_cnt++;
`endif
  endtask

  task automatic test_abort();
    int bc;
    logic ds;
    logic saw_done;
    run_op(OP_LOAD, 3'd0, 8'h0F, bc, ds);
    start = 1'b1; op = OP_ROL; amt = 3'd7;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    total_cnt++;
    if (Q !== 8'h3C || busy !== 1'b1) $display("FAIL abort_midway: Q=%h busy=%b, want 3C 1", Q, busy);
    else pass_cnt++;
    clr = 1'b1;
    @(posedge clk); @(negedge clk);
    clr = 1'b0;
    total_cnt++;
    if (Q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_clear: Q=%h busy=%b done=%b, want 00 0 0", Q, busy, done);
    else pass_cnt++;
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    total_cnt++;
    if (saw_done !== 1'b0) $display("FAIL abort_no_done: activity=%b, want 0", saw_done);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int bc;
    logic ds;
    run_op(OP_LOAD, 3'd0, 8'hFF, bc, ds);
    run_op(OP_INCR, 3'd0, 8'h00, bc, ds);
    run_op(OP_ROL, 3'd0, 8'h00, bc, ds);
    total_cnt++;
    if (Q !== 8'h00 || ds !== 1'b1 || bc != 0) $display("FAIL amt0: Q=%h done=%b busy_cycles=%0d, want 00 1 0", Q, ds, bc);
    else pass_cnt++;
`ifdef SHIFT_SFR_SEQ_CARRY_EN
    total_cnt++;
    if (carry !== 1'b1) $display("FAIL amt0_carry_held: carry=%b, want 1", carry);
    else pass_cnt++;
`endif
    run_op(OP_LOAD, 3'd0, 8'h03, bc, ds);
    // start held high; inputs change while busy must not matter
    start = 1'b1; op = OP_SHL; amt = 3'd4; din = 8'h00;
    @(posedge clk); @(negedge clk);
    op = OP_LOAD; amt = 3'd1; din = 8'hFF;
    bc = 0;
    while (busy && bc < 20) begin
      bc++;
      @(negedge clk);
    end
    total_cnt++;
    if (bc != 4 || Q !== 8'h30 || done !== 1'b1) $display("FAIL held_start_shl4: busy_cycles=%0d Q=%h done=%b, want 4 30 1", bc, Q, done);
    else pass_cnt++;
    // start still high in the done cycle: the pending load is accepted
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if (Q !== 8'hFF || done !== 1'b1 || busy !== 1'b0) $display("FAIL accept_in_done_cycle: Q=%h done=%b busy=%b, want FF 1 0", Q, done, busy);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0 || Q !== 8'hFF) $display("FAIL idle_after_b2b: done=%b Q=%h, want 0 FF", done, Q);
    else pass_cnt++;
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; op = OP_LOAD; amt = '0; din = '0;
    @(negedge clk);
    test_reset();
    test_shift();
    test_arith_rotate();
    test_wrap();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/shift_sfr_seq.md
SHIFT_SFR_SEQ -- requirements
Module: shift_sfr_seq

Interface
REQ-001 SHALL have parameter SIZE, default 32, register width in bits (minimum 2).
REQ-002 SHALL have parameter AMT_W, default 5, width of the shift-amount port (SIZE <= 2**AMT_W).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port clr  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port start  input  1  operation request; sampled only while busy=0.
REQ-006 SHALL have port op  input  3  opcode: 000 load, 001 incr, 010 decr, 011 shl, 100 shr, 101 sar, 110 rol, 111 ror.
REQ-007 SHALL have port amt  input  AMT_W  shift/rotate bit count; ignored for load/incr/decr.
REQ-008 SHALL have port din  input  SIZE  parallel load data.
REQ-009 SHALL have port Q  output  SIZE  register contents.
REQ-010 SHALL have port busy  output  1  high while a multi-cycle shift is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse on completion of every accepted operation.

Function
REQ-012 SHALL implement FSM states IDLE and SHIFT; busy=1 exactly when in SHIFT.
REQ-013 In IDLE with start=1, SHALL accept the request on that edge and latch op and amt.
REQ-014 For load, incr and decr, SHALL update Q on the accepting edge and assert done for the following cycle. Arithmetic is modulo 2**SIZE.
REQ-015 For a shift/rotate with amt=0, SHALL leave Q unchanged and assert done for the following cycle.
REQ-016 For a shift/rotate with amt=k>0, SHALL enter SHIFT on the accepting edge, with Q unchanged and counter=k.
REQ-017 In SHIFT, on each edge SHALL shift Q by one bit and decrement the counter. On the edge where the counter reaches 0, SHALL return to IDLE with done=1 for one cycle.
REQ-018 Shift semantics SHALL be as follows. shl fills the LSB with 0. shr fills the MSB with 0. sar replicates the MSB. rol moves the MSB into the LSB. ror moves the LSB into the MSB.
REQ-019 Any amt value up to 2**AMT_W-1 SHALL be honoured literally, including amt >= SIZE.
REQ-020 start while busy=1 SHALL be ignored, with no queuing and no effect on the latched op or amt.
REQ-021 start in the cycle done=1, with busy=0, SHALL be accepted normally.
REQ-022 done SHALL be 0 in every cycle other than the completion pulse. Changes to op, amt or din during SHIFT SHALL have no effect.

Reset
REQ-023 clr=1 at a clock edge SHALL force Q=0, state IDLE, counter=0, busy=0 and done=0 (carry=0 when present).
REQ-024 clr SHALL take priority over start and over any in-progress shift. An aborted shift SHALL produce no done pulse.

Configuration
REQ-025 Macro SHIFT_SFR_SEQ_CARRY_EN, when defined, SHALL add port carry  output  1  status flag, registered.
REQ-026 With the macro defined, carry SHALL be updated as follows:
- shl/rol: carry takes the bit shifted out of the MSB.
- shr/sar/ror: carry takes the bit shifted out of the LSB.
- incr: carry=1 on wrap from all-ones to 0, else 0.
- decr: carry=1 on borrow from 0 to all-ones, else 0.
- load: carry is cleared.
- amt=0: carry is held.
REQ-027 Without the macro, the carry port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (bench uses SIZE=8, AMT_W=3, macro defined)
REQ-028 Reset: clr=1 for one edge after arbitrary activity -> Q=0x00, busy=0, done=0, carry=0.
REQ-029 Shift: load 0x81, then shl amt=3 -> busy high for exactly 3 cycles; Q=0x08, carry=0; done pulses once in the cycle after the third shift edge.
REQ-030 Arithmetic and rotate: load 0x80, sar amt=2 -> Q=0xE0. Then load 0x01, ror amt=1 -> Q=0x80, carry=1.
REQ-031 Wrap: load 0xFF, incr -> Q=0x00, carry=1, done one cycle later. Then decr -> Q=0xFF, carry=1.
REQ-032 Abort: load 0x0F, rol amt=7, then clr after 2 shift edges -> Q=0x00, busy=0, no done pulse.
REQ-033 Handshake: start with amt=0 -> Q unchanged, done next cycle. Then start=1 held throughout shl amt=4 -> only the first request is executed; a second op is accepted in the done cycle.
